// File: rtl/perf_counter_unit_pkg.sv
// Shared definitions for the performance-counter unit: FSM encoding,
// counter indices and the default counter width.
package perf_counter_unit_pkg;

  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    SNAP   = 2'd3
  } state_t;

  localparam int CNT_CLK  = 0;
  localparam int CNT_INST = 1;
  localparam int CNT_HIT  = 2;
  localparam int CNT_MISS = 3;
  localparam int NUM_CNT  = 4;

endpackage

// File: rtl/sat_counter.sv
// Single event counter that either sticks at all-ones or wraps, and flags
// the cycle in which it would pass its maximum value.
module sat_counter #(
  parameter int CNT_W    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] next_count,
  output logic             ovf_pulse
);

  localparam logic [CNT_W-1:0] MAX_VAL = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic at_max;

  assign at_max    = (count == MAX_VAL);
  assign ovf_pulse = en & inc & at_max;

  // next_count is exported so the parent can snapshot the post-update value.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the output unassigned (no latch).
    next_count = count;
    if (en && inc && !(at_max && SATURATE)) begin
      next_count = count + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registered state is always written with non-blocking assignments.
    if (rst) begin
      count <= '0;
    end else begin
      count <= next_count;
    end
  end

endmodule

// File: rtl/perf_counter_unit.sv
// Counts run cycles, retired instructions and cache hits/misses between the
// first fetch and halt, with a req/ack snapshot path for debug readout.
module perf_counter_unit
  import perf_counter_unit_pkg::*;
#(
  parameter int CNT_W    = DEFAULT_CNT_W,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_valid,
  input  logic             inst_retire,
  input  logic             cache_access,
  input  logic             cache_hit,
  input  logic             halt,
  input  logic             snap_req,
  output logic             snap_ack,
  output logic [CNT_W-1:0] clk_count,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] snap_clk,
  output logic [CNT_W-1:0] snap_inst,
  output logic [CNT_W-1:0] snap_hit,
  output logic [CNT_W-1:0] snap_miss,
  output logic             ovf,
  output logic [1:0]       state
);

  state_t state_q, state_d;
  state_t ret_q, ret_d;   // state to resume after the one-cycle SNAP
  logic   count_en;

  logic [NUM_CNT-1:0] inc;
  logic [NUM_CNT-1:0] ovf_pulse;
  logic [CNT_W-1:0]   count      [NUM_CNT];
  logic [CNT_W-1:0]   next_count [NUM_CNT];

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    count_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fetch_valid) begin
          state_d  = RUN;
          count_en = 1'b1;
        end
      end
      RUN: begin
        count_en = 1'b1;
        if (snap_req) begin
          state_d = SNAP;
          ret_d   = halt ? HALTED : RUN;
        end else if (halt) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        if (snap_req) begin
          state_d = SNAP;
          ret_d   = HALTED;
        end
      end
      SNAP: begin
        // A halt seen while snapshotting from RUN still lands in HALTED.
        count_en = (ret_q == RUN);
        state_d  = (ret_q == RUN && halt) ? HALTED : ret_q;
      end
      default: state_d = IDLE;
    endcase
  end

  assign inc[CNT_CLK]  = 1'b1;
  assign inc[CNT_INST] = inst_retire;
  assign inc[CNT_HIT]  = cache_access & cache_hit;
  assign inc[CNT_MISS] = cache_access & ~cache_hit;

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    sat_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .en         (count_en),
      .inc        (inc[i]),
      .count      (count[i]),
      .next_count (next_count[i]),
      .ovf_pulse  (ovf_pulse[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ret_q     <= IDLE;
      ovf       <= 1'b0;
      snap_clk  <= '0;
      snap_inst <= '0;
      snap_hit  <= '0;
      snap_miss <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      if (|ovf_pulse) begin
        ovf <= 1'b1;
      end
      if (state_d == SNAP && state_q != SNAP) begin
        snap_clk  <= next_count[CNT_CLK];
        snap_inst <= next_count[CNT_INST];
        snap_hit  <= next_count[CNT_HIT];
        snap_miss <= next_count[CNT_MISS];
      end
    end
  end

  assign snap_ack   = (state_q == SNAP);
  assign state      = state_q;
  assign clk_count  = count[CNT_CLK];
  assign inst_count = count[CNT_INST];
  assign hit_count  = count[CNT_HIT];
  assign miss_count = count[CNT_MISS];

endmodule

// File: tb/tb_perf_counter_unit.sv
// Scoreboard bench for perf_counter_unit: a saturating and a wrapping instance
// share stimulus and are compared against an unbounded-integer reference model.
module tb_perf_counter_unit;

  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fetch_valid = 1'b0, inst_retire = 1'b0, cache_access = 1'b0;
  logic cache_hit = 1'b0, halt = 1'b0, snap_req = 1'b0;

  logic         s_ack, w_ack, s_ovf, w_ovf;
  logic [W-1:0] s_clk, s_inst, s_hit, s_miss, s_sclk, s_sinst, s_shit, s_smiss;
  logic [W-1:0] w_clk, w_inst, w_hit, w_miss, w_sclk, w_sinst, w_shit, w_smiss;
  logic [1:0]   s_state, w_state;

  always #10 clk = ~clk;

  perf_counter_unit #(.CNT_W(W), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .inst_retire(inst_retire),
    .cache_access(cache_access), .cache_hit(cache_hit), .halt(halt), .snap_req(snap_req),
    .snap_ack(s_ack), .clk_count(s_clk), .inst_count(s_inst), .hit_count(s_hit),
    .miss_count(s_miss), .snap_clk(s_sclk), .snap_inst(s_sinst), .snap_hit(s_shit),
    .snap_miss(s_smiss), .ovf(s_ovf), .state(s_state)
  );

  perf_counter_unit #(.CNT_W(W), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .inst_retire(inst_retire),
    .cache_access(cache_access), .cache_hit(cache_hit), .halt(halt), .snap_req(snap_req),
    .snap_ack(w_ack), .clk_count(w_clk), .inst_count(w_inst), .hit_count(w_hit),
    .miss_count(w_miss), .snap_clk(w_sclk), .snap_inst(w_sinst), .snap_hit(w_shit),
    .snap_miss(w_smiss), .ovf(w_ovf), .state(w_state)
  );

  // Reference model: raw event totals as plain integers, phase flags.
  typedef struct { int c; int i; int h; int m; } snap_t;
  snap_t sq[$];
  int m_clk, m_inst, m_hit, m_miss;
  bit m_started, m_halted, m_snap;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int disp(input int raw, input bit sat);
    if (sat) return (raw > MAXV) ? MAXV : raw;
    return raw % (MAXV + 1);
  endfunction

  function automatic int exp_ovf();
    return int'(m_clk > MAXV || m_inst > MAXV || m_hit > MAXV || m_miss > MAXV);
  endfunction

  function automatic int exp_state();
    if (!m_started) return 0;
    if (m_snap)     return 3;
    if (m_halted)   return 2;
    return 1;
  endfunction

  task automatic model_reset();
    m_clk = 0; m_inst = 0; m_hit = 0; m_miss = 0;
    m_started = 1'b0; m_halted = 1'b0; m_snap = 1'b0;
    sq.delete();
  endtask

  task automatic model_step(input logic fv, ir, ca, ch, h, sr);
    bit counting, enter;
    counting = m_started ? !m_halted : fv;
    enter    = m_started && !m_snap && sr;
    if (counting) begin
      m_clk++;
      m_inst += int'(ir);
      m_hit  += int'(ca & ch);
      m_miss += int'(ca & ~ch);
      if (h) m_halted = 1'b1;
    end
    if (fv) m_started = 1'b1;
    m_snap = enter;
    if (enter) sq.push_back('{m_clk, m_inst, m_hit, m_miss});
  endtask

  // Inputs change just after the falling edge; checks run 5 ns after the rising edge.
  task automatic drive(input logic fv, ir, ca, ch, h, sr);
    @(negedge clk);
    #1;
    fetch_valid = fv; inst_retire = ir; cache_access = ca;
    cache_hit = ch; halt = h; snap_req = sr;
    model_step(fv, ir, ca, ch, h, sr);
    @(posedge clk);
    #5;
  endtask

  task automatic check_live(input string tag);
    check({tag, ".clk_sat"},   s_clk,   disp(m_clk, 1'b1));
    check({tag, ".inst_sat"},  s_inst,  disp(m_inst, 1'b1));
    check({tag, ".hit_sat"},   s_hit,   disp(m_hit, 1'b1));
    check({tag, ".miss_sat"},  s_miss,  disp(m_miss, 1'b1));
    check({tag, ".ovf_sat"},   s_ovf,   exp_ovf());
    check({tag, ".state_sat"}, s_state, exp_state());
    check({tag, ".clk_wrap"},  w_clk,   disp(m_clk, 1'b0));
    check({tag, ".inst_wrap"}, w_inst,  disp(m_inst, 1'b0));
    check({tag, ".ovf_wrap"},  w_ovf,   exp_ovf());
  endtask

  task automatic check_cleared(input string tag);
    check_live(tag);
    check({tag, ".snap_ack"}, int'(s_ack | w_ack), 0);
    check({tag, ".snap_regs"}, int'(s_sclk | s_sinst | s_shit | s_smiss | w_sclk | w_smiss), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch_valid = 0; inst_retire = 0; cache_access = 0; cache_hit = 0; halt = 0; snap_req = 0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #5;
    check_cleared("reset");
    rst = 1'b0;
  endtask

  // Monitor: every queued snapshot must be acknowledged at the very next falling edge.
  snap_t e;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sq.size() > 0) begin
          e = sq.pop_front();
          check("snap_ack_sat",  s_ack, 1);
          check("snap_ack_wrap", w_ack, 1);
          check("snap_clk_sat",   s_sclk,  disp(e.c, 1'b1));
          check("snap_inst_sat",  s_sinst, disp(e.i, 1'b1));
          check("snap_hit_sat",   s_shit,  disp(e.h, 1'b1));
          check("snap_miss_sat",  s_smiss, disp(e.m, 1'b1));
          check("snap_clk_wrap",  w_sclk,  disp(e.c, 1'b0));
          check("snap_inst_wrap", w_sinst, disp(e.i, 1'b0));
          check("snap_hit_wrap",  w_shit,  disp(e.h, 1'b0));
          check("snap_miss_wrap", w_smiss, disp(e.m, 1'b0));
        end else if (s_ack || w_ack) begin
          check("unexpected_snap_ack", int'(s_ack | w_ack), 0);
        end
      end
    end
  end

  logic [9:0] ir_v, ca_v, ch_v;

  initial begin
    ir_v = 10'b1001101011;
    ca_v = 10'b0100101010;
    ch_v = 10'b0100001010;
    model_reset();
    #95;
    check_cleared("por");
    rst = 1'b0;

    // Idle: nothing counts, snap_req is ignored.
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, i >= 3);
    check_live("idle");

    // Basic run with halt at cycle 9.
    for (int i = 0; i < 10; i++) drive(i == 0, ir_v[i], ca_v[i], ch_v[i], i == 9, 0);
    check("basic.clk",   s_clk,   10);
    check("basic.inst",  s_inst,  6);
    check("basic.hit",   s_hit,   3);
    check("basic.miss",  s_miss,  1);
    check("basic.state", s_state, 2);
    repeat (20) drive(1, 1, 1, 1, 0, 0);
    check("frozen.clk",  s_clk,  10);
    check("frozen.inst", s_inst, 6);
    check_live("frozen");
    drive(0, 0, 0, 0, 0, 1);
    check("halted_snap.state", s_state, 3);
    drive(0, 0, 0, 0, 0, 0);
    check("halted_snap.return", s_state, 2);

    // Saturating versus wrapping over 300 cycles.
    do_reset();
    for (int i = 0; i < 300; i++) drive(i == 0, 1, 0, 0, 0, 0);
    check("sat.clk",   s_clk,  255);
    check("sat.inst",  s_inst, 255);
    check("sat.ovf",   s_ovf,  1);
    check("wrap.clk",  w_clk,  44);
    check("wrap.inst", w_inst, 44);
    check("wrap.ovf",  w_ovf,  1);
    check_live("sat_run");

    // Snapshot at cycle 5 of RUN, then held request, then collision with halt.
    do_reset();
    for (int i = 0; i < 5; i++) drive(i == 0, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
    drive(0, 1, 0, 0, 0, 1);
    check("run_snap.ack",   s_ack,   1);
    check("run_snap.sclk",  s_sclk,  6);
    check("run_snap.state", s_state, 3);
    drive(0, 0, 0, 0, 0, 0);
    check("run_snap.after_ack",   s_ack,   0);
    check("run_snap.after_state", s_state, 1);
    check("run_snap.after_clk",   s_clk,   7);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 0, 1);
      check_live("held_req");
    end
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 1, 1, 1);
    check("collide.state", s_state, 3);
    check("collide.sclk",  s_sclk,  disp(m_clk, 1'b1));
    drive(0, 1, 1, 0, 1, 0);
    check("collide.halted", s_state, 2);
    check_live("collide");
    repeat (5) drive(0, 1, 1, 0, 0, 0);
    check_live("collide_frozen");

    // Asynchronous reset between edges while in SNAP.
    do_reset();
    drive(1, 1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    check("async.in_snap", s_state, 3);
    rst = 1'b1;
    fetch_valid = 0; inst_retire = 0; cache_access = 0; cache_hit = 0; halt = 0; snap_req = 0;
    model_reset();
    #2;
    check_cleared("async");
    #1;
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    check("async.restart_clk", s_clk, 1);
    check_live("async_restart");

    // Randomised episodes.
    for (int ep = 0; ep < 3; ep++) begin
      do_reset();
      for (int i = 0; i < 300; i++) begin
        logic fv, h, sr;
        fv = m_started ? 1'($urandom) : ($urandom_range(3) == 0);
        h  = m_started && ($urandom_range(199) == 0);
        sr = ($urandom_range(4) == 0);
        drive(fv, 1'($urandom), 1'($urandom), 1'($urandom), h, sr);
        check_live("random");
      end
    end

    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("queue_drained", sq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
